// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: signal bundle between requesters, uart_tx and uart_tx_arbiter
//   req/req_data/req_ack          : requester handshake (N_REQ lanes)
//   tx_start/tx_data/tx_busy/tx_done : uart_tx handshake
//   grant_id/active/timeout_err   : arbiter status
//   slave  : arbiter view, master : client/uart view
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = $clog2(N_REQ);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ack;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    tx_done;
  logic [ID_W-1:0]         grant_id;
  logic                    active;
  logic                    timeout_err;
  modport master (
    output req, req_data, tx_busy, tx_done,
    input  req_ack, tx_start, tx_data, grant_id, active, timeout_err
  );
  modport slave (
    input  req, req_data, tx_busy, tx_done,
    output req_ack, tx_start, tx_data, grant_id, active, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N_REQ byte requesters
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : requester side (req, req_data, req_ack), uart_tx side
//           (tx_start, tx_data, tx_busy, tx_done) and status
//           (grant_id, active, timeout_err); all outputs registered
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d, grant_q, grant_d, sel, cand;
  logic [DATA_W-1:0] data_q, data_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              start_q, start_d, active_q, active_d, terr_q, terr_d, expire;
  // Scan downwards so the lowest offset from rr_q (first in round-robin order) wins.
  always_comb begin
    sel = '0;
    cand = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(rr_q) + i) % N_REQ);
      if (bus.req[cand]) sel = cand;
    end
  end
  // wd_q counts START/WAIT cycles from 0; abort on the edge where it would reach TIMEOUT_CYC-1.
  assign expire = TIMEOUT_CYC != 0 && 32'(wd_q) + 32'd1 >= 32'(TIMEOUT_CYC) - 32'd1;
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    grant_d = grant_q;
    data_d = data_q;
    start_d = start_q;
    active_d = active_q;
    wd_d = wd_q;
    ack_d = '0;
    terr_d = 1'b0;
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d = START;
        grant_d = sel;
        data_d = bus.req_data[sel*DATA_W +: DATA_W];
        start_d = 1'b1;
        active_d = 1'b1;
        wd_d = '0;
      end
      START, WAIT: begin
        wd_d = &wd_q ? wd_q : wd_q + 1'b1;
        // tx_done beats a simultaneous watchdog expiry
        if (bus.tx_done) begin
          state_d = DONE;
          start_d = 1'b0;
          ack_d = N_REQ'(1) << grant_q;
          rr_d = grant_q;
        end else if (expire) begin
          state_d = IDLE;
          start_d = 1'b0;
          active_d = 1'b0;
          terr_d = 1'b1;
          rr_d = grant_q;
        end else if (state_q == START && bus.tx_busy) begin
          state_d = WAIT;
          start_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        active_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= ID_W'(N_REQ - 1);
      grant_q <= '0;
      data_q <= '0;
      start_q <= 1'b0;
      active_q <= 1'b0;
      wd_q <= '0;
      ack_q <= '0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      data_q <= data_d;
      start_q <= start_d;
      active_q <= active_d;
      wd_q <= wd_d;
      ack_q <= ack_d;
      terr_q <= terr_d;
    end
  end
  assign bus.tx_start = start_q;
  assign bus.tx_data = data_q;
  assign bus.grant_id = grant_q;
  assign bus.active = active_q;
  assign bus.req_ack = ack_q;
  assign bus.timeout_err = terr_q;
endmodule
